pulse_train_gen: RTL and testbench

- Parametrised successor of the single-pulse generator: emits a burst of N identical pulses on PL_out, each D cycles high, separated by G cycles low.
- A rising edge on the selected trigger (PL_start or PL_launch) starts the burst.
- On completion it raises launch_DL to hand off to the delay-line stage. It stays in the clk_Pulse domain between the trigger logic and the delay chain.
- G=0 merges the pulses into one contiguous N*D-cycle pulse, which replaces the fixed x1/x100/x100000 multiplier modes.

---
 rtl/pulse_train_gen_if.sv | 27 ++
 rtl/pulse_train_gen.sv | 177 +++++++++++++++++
 tb/tb_pulse_train_gen.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/pulse_train_gen_if.sv
// Trigger, configuration and status bundle for the pulse-train generator.
// The bench drives through master; the generator sits on slave.
interface pulse_train_gen_if #(
  parameter int DUR_W = 21,
  parameter int NUM_W = 17
);
  logic             PL_start;
  logic             PL_launch;
  logic             src_sel;
  logic [DUR_W-1:0] duration;
  logic [DUR_W-1:0] gap;
  logic [NUM_W-1:0] pl_num;
  logic             PL_out;
  logic             launch_DL;
  logic             busy;
  logic [NUM_W-1:0] pulse_idx;

  modport master (
    output PL_start, PL_launch, src_sel, duration, gap, pl_num,
    input  PL_out, launch_DL, busy, pulse_idx
  );

  modport slave (
    input  PL_start, PL_launch, src_sel, duration, gap, pl_num,
    output PL_out, launch_DL, busy, pulse_idx
  );
endinterface

// File: rtl/pulse_train_gen.sv
// Burst generator: N pulses of D cycles high separated by G cycles low,
// started by a rising trigger edge, flagging completion on launch_DL.
module pulse_train_gen #(
  parameter int DUR_W = 21,
  parameter int NUM_W = 17
) (
  input  logic            clk_Pulse,
  input  logic            rst_Pulse_n,
  pulse_train_gen_if.slave pt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [DUR_W-1:0] DUR_ZERO = {DUR_W{1'b0}};
  localparam logic [DUR_W-1:0] DUR_ONE  = {{(DUR_W-1){1'b0}}, 1'b1};
  localparam logic [NUM_W-1:0] NUM_ZERO = {NUM_W{1'b0}};
  localparam logic [NUM_W-1:0] NUM_ONE  = {{(NUM_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  logic             trig_q_r;
  logic             armed_r;
  logic             src_r;
  logic [DUR_W-1:0] dur_r;
  logic [DUR_W-1:0] gap_r;
  logic [NUM_W-1:0] num_r;
  logic [DUR_W-1:0] cnt_r;
  logic             pl_out_r;
  logic             launch_r;
  logic             busy_r;
  logic [NUM_W-1:0] idx_r;

  logic             trig_s;
  logic             trig_lat_s;
  logic             start_s;
  logic [DUR_W-1:0] d_eff_s;
  logic             dur_end_s;
  logic             gap_end_s;
  logic             last_s;

  // Trigger selection, edge detect and terminal-count compares.
  // armed_r keeps a trigger held high through reset release from looking like an edge.
  always_comb begin
    trig_s     = pt.src_sel ? pt.PL_launch : pt.PL_start;
    trig_lat_s = src_r ? pt.PL_launch : pt.PL_start;
    start_s    = trig_s & ~trig_q_r & armed_r;
    if (pt.duration == DUR_ZERO) begin
      d_eff_s = DUR_ONE;
    end else begin
      d_eff_s = pt.duration;
    end
    dur_end_s  = (cnt_r == (dur_r - DUR_ONE));
    gap_end_s  = (cnt_r == (gap_r - DUR_ONE));
    last_s     = ((idx_r + NUM_ONE) == num_r);
  end

  // Burst state machine with registered outputs.
  always_ff @(posedge clk_Pulse or negedge rst_Pulse_n) begin
    if (!rst_Pulse_n) begin
      state_r  <= IDLE;
      trig_q_r <= 1'b0;
      armed_r  <= 1'b0;
      src_r    <= 1'b0;
      dur_r    <= DUR_ZERO;
      gap_r    <= DUR_ZERO;
      num_r    <= NUM_ZERO;
      cnt_r    <= DUR_ZERO;
      pl_out_r <= 1'b0;
      launch_r <= 1'b0;
      busy_r   <= 1'b0;
      idx_r    <= NUM_ZERO;
    end else begin
      trig_q_r <= trig_s;
      armed_r  <= 1'b1;
      case (state_r)
        IDLE: begin
          if (start_s) begin
            src_r <= pt.src_sel;
            dur_r <= d_eff_s;
            gap_r <= pt.gap;
            num_r <= pt.pl_num;
            cnt_r <= DUR_ZERO;
            idx_r <= NUM_ZERO;
            if (pt.pl_num == NUM_ZERO) begin
              state_r  <= DONE;
              launch_r <= 1'b1;
              pl_out_r <= 1'b0;
              busy_r   <= 1'b0;
            end else begin
              state_r  <= HIGH;
              pl_out_r <= 1'b1;
              busy_r   <= 1'b1;
              launch_r <= 1'b0;
            end
          end else begin
            pl_out_r <= 1'b0;
            launch_r <= 1'b0;
            busy_r   <= 1'b0;
          end
        end
        HIGH: begin
          if (!trig_lat_s) begin
            state_r  <= IDLE;
            pl_out_r <= 1'b0;
            busy_r   <= 1'b0;
            launch_r <= 1'b0;
            idx_r    <= NUM_ZERO;
            cnt_r    <= DUR_ZERO;
          end else if (dur_end_s) begin
            cnt_r <= DUR_ZERO;
            idx_r <= idx_r + NUM_ONE;
            if (last_s) begin
              state_r  <= DONE;
              pl_out_r <= 1'b0;
              launch_r <= 1'b1;
              busy_r   <= 1'b0;
            end else if (gap_r != DUR_ZERO) begin
              state_r  <= LOW;
              pl_out_r <= 1'b0;
            end else begin
              // Zero gap: stay high so consecutive pulses merge without a glitch.
              state_r  <= HIGH;
              pl_out_r <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + DUR_ONE;
          end
        end
        LOW: begin
          if (!trig_lat_s) begin
            state_r  <= IDLE;
            pl_out_r <= 1'b0;
            busy_r   <= 1'b0;
            launch_r <= 1'b0;
            idx_r    <= NUM_ZERO;
            cnt_r    <= DUR_ZERO;
          end else if (gap_end_s) begin
            state_r  <= HIGH;
            pl_out_r <= 1'b1;
            cnt_r    <= DUR_ZERO;
          end else begin
            cnt_r <= cnt_r + DUR_ONE;
          end
        end
        DONE: begin
          if (!trig_lat_s) begin
            state_r  <= IDLE;
            launch_r <= 1'b0;
            idx_r    <= NUM_ZERO;
          end else begin
            launch_r <= 1'b1;
          end
          pl_out_r <= 1'b0;
          busy_r   <= 1'b0;
        end
        default: begin
          state_r  <= IDLE;
          pl_out_r <= 1'b0;
          launch_r <= 1'b0;
          busy_r   <= 1'b0;
          idx_r    <= NUM_ZERO;
          cnt_r    <= DUR_ZERO;
        end
      endcase
    end
  end

  assign pt.PL_out    = pl_out_r;
  assign pt.launch_DL = launch_r;
  assign pt.busy      = busy_r;
  assign pt.pulse_idx = idx_r;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed scoreboard bench for pulse_train_gen: expected per-cycle outputs
// are queued when a trigger is applied and checked one clock at a time.
module tb_pulse_train_gen;
  localparam int DUR_W = 21;
  localparam int NUM_W = 17;

  typedef struct packed {
    logic             pl;
    logic             ld;
    logic             bz;
    logic [NUM_W-1:0] idx;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;
  exp_t exp_q[$];

  pulse_train_gen_if #(.DUR_W(DUR_W), .NUM_W(NUM_W)) ifc ();

  pulse_train_gen #(.DUR_W(DUR_W), .NUM_W(NUM_W)) dut (
    .clk_Pulse   (clk),
    .rst_Pulse_n (rst_n),
    .pt          (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int cyc, input logic [31:0] got,
                     input logic [31:0] want);
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s cyc %0d: got %0h want %0h", tag, cyc, got, want);
    end
  endtask

  task automatic push(input logic pl, input logic ld, input logic bz,
                      input int idx, input int cnt);
    exp_t e;
    e.pl  = pl;
    e.ld  = ld;
    e.bz  = bz;
    e.idx = NUM_W'(idx);
    repeat (cnt) exp_q.push_back(e);
  endtask

  // Expected samples from the first trigger-high edge through the hold in DONE.
  task automatic push_burst(input int d, input int g, input int n, input int hold);
    int de;
    de = (d == 0) ? 1 : d;
    for (int p = 0; p < n; p++) begin
      push(1'b1, 1'b0, 1'b1, p, de);
      if (p < n - 1) push(1'b0, 1'b0, 1'b1, p + 1, g);
    end
    push(1'b0, 1'b1, 1'b0, n, hold);
  endtask

  task automatic drain(input string tag, input int chg_at);
    exp_t e;
    int   i;
    i = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      i++;
      chk({tag, ".pl_out"},    i, 32'(ifc.PL_out),    32'(e.pl));
      chk({tag, ".launch_dl"}, i, 32'(ifc.launch_DL), 32'(e.ld));
      chk({tag, ".busy"},      i, 32'(ifc.busy),      32'(e.bz));
      chk({tag, ".pulse_idx"}, i, 32'(ifc.pulse_idx), 32'(e.idx));
      if (i == chg_at) begin
        ifc.duration = 21'd7;
        ifc.gap      = 21'd5;
        ifc.src_sel  = ~ifc.src_sel;
      end
    end
  endtask

  task automatic set_trig(input logic src, input logic v);
    if (src) ifc.PL_launch = v;
    else     ifc.PL_start  = v;
  endtask

  task automatic run(input string tag, input logic src, input int d, input int g,
                     input int n, input int hold, input int chg_at);
    ifc.src_sel  = src;
    ifc.duration = DUR_W'(d);
    ifc.gap      = DUR_W'(g);
    ifc.pl_num   = NUM_W'(n);
    set_trig(src, 1'b1);
    push_burst(d, g, n, hold);
    drain(tag, chg_at);
    set_trig(src, 1'b0);
    ifc.src_sel = src;
    push(1'b0, 1'b0, 1'b0, 0, 2);
    drain({tag, "_end"}, 0);
  endtask

  initial begin
    n_assert      = 0;
    n_fail        = 0;
    rst_n         = 1'b1;
    ifc.PL_start  = 1'b0;
    ifc.PL_launch = 1'b0;
    ifc.src_sel   = 1'b0;
    ifc.duration  = 21'd0;
    ifc.gap       = 21'd0;
    ifc.pl_num    = 17'd0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst.pl_out",    0, 32'(ifc.PL_out),    32'd0);
    chk("rst.launch_dl", 0, 32'(ifc.launch_DL), 32'd0);
    chk("rst.busy",      0, 32'(ifc.busy),      32'd0);
    chk("rst.pulse_idx", 0, 32'(ifc.pulse_idx), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    push(1'b0, 1'b0, 1'b0, 0, 3);
    drain("idle", 0);

    run("single", 1'b0, 5, 0, 1, 3, 0);
    run("train", 1'b1, 3, 2, 4, 2, 0);
    run("merge", 1'b0, 4, 0, 100, 1, 0);

    // Abort during the second HIGH: 24 samples, then the trigger drops.
    ifc.src_sel  = 1'b0;
    ifc.duration = 21'd10;
    ifc.gap      = 21'd10;
    ifc.pl_num   = 17'd5;
    ifc.PL_start = 1'b1;
    push(1'b1, 1'b0, 1'b1, 0, 10);
    push(1'b0, 1'b0, 1'b1, 1, 10);
    push(1'b1, 1'b0, 1'b1, 1, 4);
    drain("abort_pre", 0);
    ifc.PL_start = 1'b0;
    push(1'b0, 1'b0, 1'b0, 0, 4);
    drain("abort", 0);
    run("abort_restart", 1'b0, 10, 10, 5, 1, 0);

    run("n_zero", 1'b1, 5, 3, 0, 3, 0);
    run("d_zero", 1'b0, 0, 1, 3, 1, 0);
    run("cfg_change", 1'b0, 3, 2, 3, 2, 4);

    // Asynchronous reset between edges while high, trigger kept high.
    ifc.src_sel  = 1'b0;
    ifc.duration = 21'd20;
    ifc.gap      = 21'd0;
    ifc.pl_num   = 17'd1;
    ifc.PL_start = 1'b1;
    push(1'b1, 1'b0, 1'b1, 0, 5);
    drain("areset_pre", 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("areset.pl_out",    0, 32'(ifc.PL_out),    32'd0);
    chk("areset.busy",      0, 32'(ifc.busy),      32'd0);
    chk("areset.launch_dl", 0, 32'(ifc.launch_DL), 32'd0);
    chk("areset.pulse_idx", 0, 32'(ifc.pulse_idx), 32'd0);
    #2;
    rst_n = 1'b1;
    push(1'b0, 1'b0, 1'b0, 0, 4);
    drain("areset_held", 0);
    ifc.PL_start = 1'b0;
    push(1'b0, 1'b0, 1'b0, 0, 2);
    drain("areset_low", 0);
    run("areset_retrig", 1'b0, 2, 0, 1, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
